// File: rtl/hs_ram_ctrl.sv
// Parametrised data RAM behind the CPU four-phase trigger/ready handshake.
// Optional err_out port and error logic are enabled by defining HS_RAM_ERR_EN.
module hs_ram_ctrl #(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          trigger_in,
    input  logic          rw_in,
    input  logic [AW-1:0] addr_in,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          ready_out
`ifdef HS_RAM_ERR_EN
    ,
    output logic          err_out
`endif
);

    localparam int OFS = $clog2(DW / 8);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_e;

    logic trig_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign trig_s = trigger_in;
        end else if (SYNC_STAGES == 1) begin : g_sync1
            logic sync_q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) sync_q <= 1'b0;
                else        sync_q <= trigger_in;
            end
            assign trig_s = sync_q;
        end else begin : g_syncn
            logic [SYNC_STAGES-1:0] sync_q, sync_d;
            assign sync_d = {sync_q[SYNC_STAGES-2:0], trigger_in};
            // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) sync_q <= '0;
                else        sync_q <= sync_d;
            end
            assign trig_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rw_q, rw_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] word_idx;
    logic [IW-1:0] mem_idx;
    logic          in_range;
    logic          access_err;
    logic          mem_we;

    assign word_idx = addr_q >> OFS;
    assign mem_idx  = word_idx[IW-1:0];
    assign in_range = word_idx < AW'(DEPTH);

`ifdef HS_RAM_ERR_EN
    localparam logic [AW-1:0] ALIGN_MASK = AW'((64'd1 << OFS) - 64'd1);
    assign access_err = !in_range || (|(addr_q & ALIGN_MASK));
`else
    assign access_err = 1'b0;
`endif

    // NOTE: every always_comb output is given a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        ready_d    = ready_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trig_s) begin
                    addr_d  = addr_in;
                    rw_d    = rw_in;
                    wdata_d = data_in;
                    cnt_d   = 8'd0;
                    state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (cnt_q == 8'(WAIT_STATES - 1)) state_d = ACCESS;
                else                              cnt_d   = cnt_q + 8'd1;
            end
            ACCESS: begin
                ready_d = 1'b1;
                err_d   = access_err;
                if (rw_q) mem_we     = in_range;
                else      data_out_d = in_range ? mem[mem_idx] : '0;
                state_d = DONE;
            end
            DONE: begin
                // An early trigger drop lands here too, giving a one-cycle ready pulse.
                if (!trig_s) begin
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            wdata_q    <= '0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    // NOTE: storage has no reset; contents survive reset and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= wdata_q;
    end

    assign data_out  = data_out_q;
    assign ready_out = ready_q;
`ifdef HS_RAM_ERR_EN
    assign err_out   = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_hs_ram_ctrl.sv
// Self-checking bench for hs_ram_ctrl: three instances (W0/S2, W3/S2, W5/S0), table vectors
// plus hand-written reset and early-drop sequences; expected results flow through a scoreboard queue.
module tb_hs_ram_ctrl;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n [3];
    logic        trig  [3];
    logic        rw    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] dout  [3];
    logic        rdy   [3];
`ifdef HS_RAM_ERR_EN
    logic        err   [3];
`endif

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb_q[$];
    vec_t vecs[13];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hs_ram_ctrl #(.DW(32), .AW(32), .DEPTH(256), .WAIT_STATES(0), .SYNC_STAGES(2)) u_a (
        .clk(clk), .reset(rst_n[0]), .trigger_in(trig[0]), .rw_in(rw[0]), .addr_in(addr[0]),
        .data_in(wdata[0]), .data_out(dout[0]), .ready_out(rdy[0])
`ifdef HS_RAM_ERR_EN
        , .err_out(err[0])
`endif
    );

    hs_ram_ctrl #(.DW(32), .AW(32), .DEPTH(256), .WAIT_STATES(3), .SYNC_STAGES(2)) u_b (
        .clk(clk), .reset(rst_n[1]), .trigger_in(trig[1]), .rw_in(rw[1]), .addr_in(addr[1]),
        .data_in(wdata[1]), .data_out(dout[1]), .ready_out(rdy[1])
`ifdef HS_RAM_ERR_EN
        , .err_out(err[1])
`endif
    );

    hs_ram_ctrl #(.DW(32), .AW(32), .DEPTH(256), .WAIT_STATES(5), .SYNC_STAGES(0)) u_c (
        .clk(clk), .reset(rst_n[2]), .trigger_in(trig[2]), .rw_in(rw[2]), .addr_in(addr[2]),
        .data_in(wdata[2]), .data_out(dout[2]), .ready_out(rdy[2])
`ifdef HS_RAM_ERR_EN
        , .err_out(err[2])
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One full four-phase transaction; checks rise latency, data/err via the scoreboard, fall latency.
    task automatic run_txn(input int k, input logic rwv, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_d, input logic exp_e,
                           input int rise_lat, input int fall_lat, input string name);
        exp_t e;
        int   n;
        e.data = exp_d;
        e.err  = exp_e;
        sb_q.push_back(e);
        @(negedge clk);
        rw[k] = rwv; addr[k] = a; wdata[k] = d; trig[k] = 1'b1;
        n = 0;
        while (n < 60) begin
            @(posedge clk); n++; #1;
            if (rdy[k]) break;
        end
        check({name, " rise"}, 64'(n), 64'(rise_lat));
        e = sb_q.pop_front();
        check({name, " data"}, 64'(dout[k]), 64'(e.data));
`ifdef HS_RAM_ERR_EN
        check({name, " err"}, 64'(err[k]), 64'(e.err));
`endif
        @(negedge clk);
        trig[k] = 1'b0;
        n = 0;
        while (n < 60) begin
            @(posedge clk); n++; #1;
            if (!rdy[k]) break;
        end
        check({name, " fall"}, 64'(n), 64'(fall_lat));
    endtask

    initial begin
        int   n;
        int   highs;
        logic [31:0] seen;
        exp_t e;

        vecs[0]  = '{1'b1, 32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h000, 32'h12345678, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b0, 32'h000, 32'h0,        32'h12345678, 1'b0};
        vecs[4]  = '{1'b1, 32'h400, 32'hFFFFFFFF, 32'h12345678, 1'b1};
        vecs[5]  = '{1'b0, 32'h400, 32'h0,        32'h00000000, 1'b1};
        vecs[6]  = '{1'b0, 32'h000, 32'h0,        32'h12345678, 1'b0};
        vecs[7]  = '{1'b1, 32'h010, 32'hA5A5A5A5, 32'h12345678, 1'b0};
        vecs[8]  = '{1'b0, 32'h013, 32'h0,        32'hA5A5A5A5, 1'b1};
        vecs[9]  = '{1'b0, 32'h010, 32'h0,        32'hA5A5A5A5, 1'b0};
        vecs[10] = '{1'b1, 32'h3FC, 32'h0BADF00D, 32'hA5A5A5A5, 1'b0};
        vecs[11] = '{1'b0, 32'h3FC, 32'h0,        32'h0BADF00D, 1'b0};
        vecs[12] = '{1'b0, 32'h000, 32'h0,        32'h12345678, 1'b0};

        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; trig[k] = 1'b0; rw[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset rdy%0d", k), 64'(rdy[k]), 64'd0);
            check($sformatf("reset dout%0d", k), 64'(dout[k]), 64'd0);
        end

        // Instance A: W=0, S=2 -> rise on edge 4, fall 3 edges after trigger drop.
        for (int i = 0; i < 13; i++)
            run_txn(0, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp_data,
                    vecs[i].exp_err, 4, 3, $sformatf("vec%0d", i));

        // Instance B: W=3, S=2 -> rise on edge 7.
        run_txn(1, 1'b1, 32'h0, 32'h12345678, 32'h0, 1'b0, 7, 3, "waitw");
        run_txn(1, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0, 7, 3, "waitr");

        // Instance C: W=5, S=0 -> rise on edge 7, fall 1 edge after trigger drop.
        run_txn(2, 1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0, 7, 1, "c_w1");

        // Reset during WAIT of a second write: it must never commit.
        @(negedge clk);
        rw[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'h22222222; trig[2] = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n[2] = 1'b0;
        #1 check("rst_wait rdy", 64'(rdy[2]), 64'd0);
        @(negedge clk); trig[2] = 1'b0;
        @(negedge clk); rst_n[2] = 1'b1;
        run_txn(2, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 7, 1, "c_r_after_rst");

        // Reset while in DONE: ready_out and data_out drop at once.
        @(negedge clk);
        rw[2] = 1'b0; addr[2] = 32'h20; trig[2] = 1'b1;
        n = 0;
        while (n < 60 && !rdy[2]) begin @(posedge clk); n++; #1; end
        check("rst_done rise", 64'(n), 64'd7);
        #2 rst_n[2] = 1'b0;
        #1 check("rst_done rdy", 64'(rdy[2]), 64'd0);
        check("rst_done dout", 64'(dout[2]), 64'd0);
        @(negedge clk); trig[2] = 1'b0;
        @(negedge clk); rst_n[2] = 1'b1;

        // Early trigger drop: trigger sampled high on one edge only.
        e.data = 32'h11111111; e.err = 1'b0;
        sb_q.push_back(e);
        @(negedge clk);
        rw[2] = 1'b0; addr[2] = 32'h20; trig[2] = 1'b1;
        @(negedge clk);
        trig[2] = 1'b0;
        highs = 0; seen = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rdy[2]) begin highs++; seen = dout[2]; end
        end
        check("early_drop pulse", 64'(highs), 64'd1);
        e = sb_q.pop_front();
        check("early_drop data", 64'(seen), 64'(e.data));
        run_txn(2, 1'b1, 32'h24, 32'h5A5A0000, 32'h11111111, 1'b0, 7, 1, "c_after_drop_w");
        run_txn(2, 1'b0, 32'h24, 32'h0, 32'h5A5A0000, 1'b0, 7, 1, "c_after_drop_r");

        check("scoreboard empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
